// File: rtl/video_pkg.sv
// Shared definitions for the cell fetch / pixel shifter video path.
package video_pkg;

  localparam logic [1:0] MODE_TEXT = 2'b00;
  localparam logic [1:0] MODE_HR2  = 2'b01;
  localparam logic [1:0] MODE_HR4  = 2'b10;

  typedef struct packed {
    logic [7:0] glyph;
    logic [7:0] vid;
    logic [3:0] att;
    logic [1:0] md;
  } cell_t;

  localparam int CELL_BITS = $bits(cell_t);

  // log2 of pce slots each pixel is held, given log2 slots per cell and log2 pixels per cell
  function automatic int hold_shift(input int slot_log2, input int pix_log2);
    return (slot_log2 > pix_log2) ? slot_log2 - pix_log2 : 0;
  endfunction

endpackage

// File: rtl/video_shifter.sv
// Holds the cell currently on screen and turns it into ven/color per pixel slot
// for text (1bpp), hi-res 2bpp and 4bpp modes.
module video_shifter
  import video_pkg::*;
#(
  parameter int         CELLW = 8,
  parameter logic [3:0] PAL1  = 4'h8,
  parameter logic [3:0] PAL2  = 4'h2,
  parameter logic [3:0] PAL3  = 4'h5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       load,
  input  logic       pce,
  input  logic [1:0] md,
  input  logic [7:0] glyph,
  input  logic [7:0] vid,
  input  logic [3:0] att,
  output logic       ven,
  output logic [3:0] color
);

  localparam int SW     = $clog2(CELLW);
  localparam int TXT_SH = hold_shift(SW, 3);
  localparam int HR2_SH = hold_shift(SW, 2);
  localparam int HR4_SH = hold_shift(SW, 1);

  logic [SW-1:0] px_q, px_d;
  cell_t         cur_q, cur_d;
  logic [4:0]    px_w;
  logic [2:0]    tidx;
  logic [1:0]    hidx;
  logic          qidx;
  logic [1:0]    code;
  logic [3:0]    nib;

  always_comb begin
    px_d  = px_q;
    cur_d = cur_q;
    if (clr) begin
      px_d  = '0;
      cur_d = '0;
    end else if (load) begin
      px_d  = '0;
      cur_d = '{glyph: glyph, vid: vid, att: att, md: md};
    end else if (pce) begin
      px_d = px_q + SW'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments only; all combinational next-state lives in always_comb.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      px_q  <= '0;
      cur_q <= '0;
    end else begin
      px_q  <= px_d;
      cur_q <= cur_d;
    end
  end

  always_comb begin
    px_w  = 5'(px_q);
    tidx  = 3'(px_w >> TXT_SH);
    hidx  = 2'(px_w >> HR2_SH);
    qidx  = 1'(px_w >> HR4_SH);
    nib   = qidx ? cur_q.vid[3:0] : cur_q.vid[7:4];
    case (hidx)
      2'd0:    code = cur_q.vid[7:6];
      2'd1:    code = cur_q.vid[5:4];
      2'd2:    code = cur_q.vid[3:2];
      default: code = cur_q.vid[1:0];
    endcase
    ven   = 1'b0;
    color = '0;
    case (cur_q.md)
      MODE_HR2: begin
        ven = (code != 2'd0);
        case (code)
          2'd1:    color = PAL1;
          2'd2:    color = PAL2;
          2'd3:    color = PAL3;
          default: color = 4'h0;
        endcase
      end
      MODE_HR4: begin
        ven   = (nib != 4'd0);
        color = nib;
      end
      default: begin
        // mode 11 lands here and renders as text
        ven   = cur_q.glyph[3'd7 - tidx];
        color = cur_q.att;
      end
    endcase
  end

endmodule

// File: rtl/video_fetch.sv
// Per-cell fetch pipeline: video/attr RAM -> glyph (font ROM or user char RAM) ->
// pending cell buffer, handed to the shifter at the end of each cell.
module video_fetch
  import video_pkg::*;
#(
  parameter int         CELLW = 8,
  parameter int         MAW   = 14,
  parameter int         RAW   = 3,
  parameter logic [3:0] PAL1  = 4'h8,
  parameter logic [3:0] PAL2  = 4'h2,
  parameter logic [3:0] PAL3  = 4'h5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hsync,
  input  logic               pce,
  input  logic [MAW-1:0]     ma,
  input  logic [RAW-1:0]     ra,
  input  logic               b,
  input  logic               c,
  input  logic [1:0]         mode,
  output logic [MAW-1:0]     vramA,
  input  logic [7:0]         vramQ,
  output logic [9:0]         attrA,
  input  logic [7:0]         attrQ,
  output logic [8+RAW-1:0]   fontA,
  input  logic [7:0]         fontQ,
  output logic [7+RAW-1:0]   chrA,
  input  logic [7:0]         chrQ,
  output logic               ven,
  output logic [3:0]         color
);

  localparam int SW = $clog2(CELLW);

  logic [SW-1:0]    sc_q, sc_d;
  logic [MAW-1:0]   vram_a_q, vram_a_d;
  logic [9:0]       attr_a_q, attr_a_d;
  logic [8+RAW-1:0] font_a_q, font_a_d;
  logic [7+RAW-1:0] chr_a_q, chr_a_d;
  logic             ds_q, ds_d;
  cell_t            pend_q, pend_d;
  logic             load;
  logic             unused_attr_hi;

  assign unused_attr_hi = ^attrQ[7:4];

  // NOTE: every _d defaults to its _q before any branch, so no path leaves a latch behind.
  always_comb begin
    sc_d     = sc_q;
    vram_a_d = vram_a_q;
    attr_a_d = attr_a_q;
    font_a_d = font_a_q;
    chr_a_d  = chr_a_q;
    ds_d     = ds_q;
    pend_d   = pend_q;
    load     = 1'b0;
    if (hsync) begin
      sc_d   = '0;
      ds_d   = 1'b0;
      pend_d = '0;
    end else if (pce) begin
      sc_d = sc_q + SW'(1);
      load = (sc_q == SW'(CELLW - 1));
      if (sc_q == SW'(0)) begin
        vram_a_d = ma;
        attr_a_d = ma[9:0];
      end
      if (sc_q == SW'(1)) begin
        pend_d.vid = vramQ;
        pend_d.att = attrQ[3:0];
        pend_d.md  = mode;
      end
      if (sc_q == SW'(2)) begin
        font_a_d = {pend_q.vid, ra};
        chr_a_d  = {pend_q.vid[6:0], ra};
        ds_d     = pend_q.vid[7] && ((!c && !pend_q.vid[6]) || (!b && pend_q.vid[6]));
      end
      if (sc_q == SW'(3)) begin
        pend_d.glyph = ds_q ? chrQ : fontQ;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sc_q     <= '0;
      vram_a_q <= '0;
      attr_a_q <= '0;
      font_a_q <= '0;
      chr_a_q  <= '0;
      ds_q     <= 1'b0;
      pend_q   <= '0;
    end else begin
      sc_q     <= sc_d;
      vram_a_q <= vram_a_d;
      attr_a_q <= attr_a_d;
      font_a_q <= font_a_d;
      chr_a_q  <= chr_a_d;
      ds_q     <= ds_d;
      pend_q   <= pend_d;
    end
  end

  assign vramA = vram_a_q;
  assign attrA = attr_a_q;
  assign fontA = font_a_q;
  assign chrA  = chr_a_q;

  // Shifter takes pend_d so a glyph landing on the wrap slot (CELLW=4) is not a cell late.
  video_shifter #(
    .CELLW (CELLW),
    .PAL1  (PAL1),
    .PAL2  (PAL2),
    .PAL3  (PAL3)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .clr   (hsync),
    .load  (load),
    .pce   (pce),
    .md    (pend_d.md),
    .glyph (pend_d.glyph),
    .vid   (pend_d.vid),
    .att   (pend_d.att),
    .ven   (ven),
    .color (color)
  );

endmodule

// File: tb/tb_video_fetch.sv
// Self-checking bench for video_fetch: directed vector table, hand-written corner
// sequences, and randomized lines checked against a per-cell behavioural model.
module tb_video_fetch;
  import video_pkg::*;

  localparam int CELLW = 8;
  localparam int MAW   = 14;
  localparam int RAW   = 3;
  localparam int NSLOT = 256;

  logic               clock = 1'b0;
  logic               reset, hsync, pce, b, c;
  logic [MAW-1:0]     ma;
  logic [RAW-1:0]     ra;
  logic [1:0]         mode;
  logic [MAW-1:0]     vramA;
  logic [7:0]         vramQ, attrQ, fontQ, chrQ;
  logic [9:0]         attrA;
  logic [8+RAW-1:0]   fontA;
  logic [7+RAW-1:0]   chrA;
  logic               ven;
  logic [3:0]         color;

  logic [7:0] vram_m [1<<MAW];
  logic [7:0] attr_m [1024];
  logic [7:0] font_m [1<<(8+RAW)];
  logic [7:0] chr_m  [1<<(7+RAW)];

  assign vramQ = vram_m[vramA];
  assign attrQ = attr_m[attrA];
  assign fontQ = font_m[fontA];
  assign chrQ  = chr_m[chrA];

  always #5 clock = ~clock;

  video_fetch #(.CELLW(CELLW), .MAW(MAW), .RAW(RAW)) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .pce(pce), .ma(ma), .ra(ra),
    .b(b), .c(c), .mode(mode), .vramA(vramA), .vramQ(vramQ), .attrA(attrA),
    .attrQ(attrQ), .fontA(fontA), .fontQ(fontQ), .chrA(chrA), .chrQ(chrQ),
    .ven(ven), .color(color)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pixel p of a cell, straight from the mode rules (CELLW >= 8).
  function automatic logic [4:0] ref_pixel(input logic [7:0] glyph, input logic [7:0] vid,
                                           input logic [3:0] att, input logic [1:0] md, input int p);
    int code;
    int nib;
    if (md == 2'b01) begin
      code = (int'(vid) >> (6 - 2 * (p / (CELLW / 4)))) & 3;
      case (code)
        1:       return 5'h18;
        2:       return 5'h12;
        3:       return 5'h15;
        default: return 5'h00;
      endcase
    end else if (md == 2'b10) begin
      nib = (int'(vid) >> (4 - 4 * (p / (CELLW / 2)))) & 15;
      return {nib != 0, 4'(nib)};
    end
    return {glyph[7 - p / (CELLW / 8)], att};
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  vid;
    logic [3:0]  att;
    logic [1:0]  md;
    logic        b, c;
    logic [7:0]  font, chr;
    logic [7:0]  ven_e;
    logic [31:0] col_e;
  } vec_t;

  vec_t vt [8];

  task automatic run_vec(input int n);
    logic [MAW-1:0] addr;
    logic [RAW-1:0] r;
    logic [7:0]     ve;
    logic [31:0]    ce;
    int             p;
    addr = MAW'($urandom);
    r    = RAW'($urandom);
    vram_m[addr]                    = vt[n].vid;
    attr_m[addr[9:0]]               = {4'($urandom), vt[n].att};
    font_m[{vt[n].vid, r}]          = vt[n].font;
    chr_m[{vt[n].vid[6:0], r}]      = vt[n].chr;
    ve = vt[n].ven_e;
    ce = vt[n].col_e;
    @(negedge clock);
    hsync = 1'b1; pce = 1'b1; ma = addr; ra = r;
    mode = vt[n].md; b = vt[n].b; c = vt[n].c;
    @(negedge clock);
    hsync = 1'b0;
    for (int k = 1; k < 2 * CELLW; k++) begin
      @(negedge clock);
      if (k == 3) begin
        check($sformatf("vec%0d_fontA", n), 32'(fontA), 32'({vt[n].vid, r}));
        check($sformatf("vec%0d_chrA", n), 32'(chrA), 32'({vt[n].vid[6:0], r}));
      end
      if (k >= CELLW) begin
        p = k - CELLW;
        check($sformatf("vec%0d_px%0d", n, p), 32'({ven, color}),
              32'({ve[7 - p], 4'(ce >> (28 - 4 * p))}));
      end
    end
  endtask

  // ---------------- randomized lines ----------------
  logic [MAW-1:0] ma_s   [NSLOT];
  logic [1:0]     mode_s [NSLOT];
  logic           b_s    [NSLOT];
  logic           c_s    [NSLOT];
  logic [RAW-1:0] ra_s   [NSLOT];

  function automatic logic [4:0] exp_rand(input int ed);
    int             t, k, p, base;
    logic [MAW-1:0] a;
    logic [7:0]     v, g;
    logic           bb, cc, ds;
    logic [RAW-1:0] r;
    if (ed < CELLW) return 5'h0;
    t    = ed - CELLW;
    k    = t / CELLW;
    p    = t % CELLW;
    base = k * CELLW;
    a    = ma_s[base];
    v    = vram_m[a];
    bb   = b_s[base + 2];
    cc   = c_s[base + 2];
    r    = ra_s[base + 2];
    ds   = v[7] && ((!cc && !v[6]) || (!bb && v[6]));
    g    = ds ? chr_m[{v[6:0], r}] : font_m[{v, r}];
    return ref_pixel(g, v, attr_m[a[9:0]][3:0], mode_s[base + 1], p);
  endfunction

  task automatic random_line(input int ncells);
    int ed, target, guard;
    @(negedge clock);
    hsync = 1'b1; pce = 1'($urandom); ma = MAW'($urandom);
    @(negedge clock);
    hsync  = 1'b0;
    ed     = 0;
    target = ncells * CELLW + CELLW - 1;
    guard  = 0;
    while (guard < 4000) begin
      check($sformatf("rnd_e%0d", ed), 32'({ven, color}), 32'(exp_rand(ed)));
      if (ed >= target) break;
      pce  = ($urandom_range(0, 3) != 0);
      ma   = MAW'($urandom);
      mode = 2'($urandom);
      b    = 1'($urandom);
      c    = 1'($urandom);
      ra   = RAW'($urandom);
      if (pce) begin
        ma_s[ed] = ma; mode_s[ed] = mode; b_s[ed] = b; c_s[ed] = c; ra_s[ed] = ra;
        ed++;
      end
      @(negedge clock);
      guard++;
    end
    check("rnd_budget", 32'(ed >= target), 32'd1);
  endtask

  logic [MAW-1:0] addr, addr2;
  logic [RAW-1:0] r0;

  initial begin
    for (int i = 0; i < (1 << MAW); i++) vram_m[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) attr_m[i] = 8'($urandom);
    for (int i = 0; i < (1 << (8 + RAW)); i++) font_m[i] = 8'($urandom);
    for (int i = 0; i < (1 << (7 + RAW)); i++) chr_m[i] = 8'($urandom);

    //            vid    att   md     b     c     font   chr    ven    colours
    vt[0] = '{8'h41, 4'hC, 2'b00, 1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5, 32'hCCCCCCCC};
    vt[1] = '{8'hC3, 4'h3, 2'b00, 1'b0, 1'b1, 8'h00, 8'hFF, 8'hFF, 32'h33333333};
    vt[2] = '{8'h85, 4'h6, 2'b00, 1'b1, 1'b0, 8'h00, 8'h96, 8'h96, 32'h66666666};
    vt[3] = '{8'hC3, 4'h9, 2'b00, 1'b1, 1'b0, 8'h5A, 8'hFF, 8'h5A, 32'h99999999};
    vt[4] = '{8'h1B, 4'hF, 2'b01, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'h3F, 32'h00882255};
    vt[5] = '{8'h7E, 4'h1, 2'b10, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 32'h7777EEEE};
    vt[6] = '{8'h22, 4'hA, 2'b11, 1'b1, 1'b1, 8'h3C, 8'h00, 8'h3C, 32'hAAAAAAAA};
    vt[7] = '{8'hE4, 4'h4, 2'b01, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFC, 32'h55228800};

    reset = 1'b1; hsync = 1'b0; pce = 1'b1; ma = 14'h1ABC; ra = 3'd5;
    b = 1'b1; c = 1'b1; mode = 2'b00;
    repeat (3) @(negedge clock);
    check("rst_out", 32'({ven, color}), 32'h0);
    check("rst_vramA", 32'(vramA), 32'h0);
    check("rst_attrA", 32'(attrA), 32'h0);
    check("rst_fontA", 32'(fontA), 32'h0);
    check("rst_chrA", 32'(chrA), 32'h0);
    reset = 1'b0;

    for (int n = 0; n < 8; n++) run_vec(n);

    // hsync at sc==5 mid-cell; restarted line uses an address aliasing the same attr entry
    addr  = 14'h0123;
    addr2 = addr + 14'h0400;
    r0    = 3'd2;
    vram_m[addr] = 8'h41; vram_m[addr2] = 8'h41;
    attr_m[addr[9:0]] = 8'h3C; font_m[{8'h41, r0}] = 8'hFF;
    @(negedge clock);
    hsync = 1'b1; pce = 1'b1; ma = addr; ra = r0; mode = 2'b00; b = 1'b1; c = 1'b1;
    @(negedge clock);
    hsync = 1'b0;
    repeat (CELLW + 5) @(negedge clock);
    check("hs_before", 32'({ven, color}), 32'h1C);
    hsync = 1'b1; ma = 14'h3FFF;
    @(negedge clock);
    check("hs_clear", 32'({ven, color}), 32'h0);
    hsync = 1'b0; ma = addr2;
    for (int k = 1; k <= CELLW; k++) begin
      @(negedge clock);
      if (k == 1)         check("hs_sc0_vramA", 32'(vramA), 32'(addr2));
      if (k == CELLW - 1) check("hs_not_yet", 32'({ven, color}), 32'h0);
      if (k == CELLW)     check("hs_resume", 32'({ven, color}), 32'h1C);
    end

    // mode 00 -> 01 before the sc==4 slot of cell 0: cell 0 text, cell 1 hi-res
    vram_m[addr] = 8'h1B; font_m[{8'h1B, r0}] = 8'hA5;
    @(negedge clock);
    hsync = 1'b1; ma = addr; mode = 2'b00;
    @(negedge clock);
    hsync = 1'b0;
    for (int k = 1; k < 3 * CELLW; k++) begin
      @(negedge clock);
      if (k == 4) mode = 2'b01;
      if (k >= CELLW && k < 2 * CELLW)
        check($sformatf("m6_text%0d", k - CELLW), 32'({ven, color}),
              32'(ref_pixel(8'hA5, 8'h1B, 4'hC, 2'b00, k - CELLW)));
      if (k >= 2 * CELLW)
        check($sformatf("m6_hr2_%0d", k - 2 * CELLW), 32'({ven, color}),
              32'(ref_pixel(8'hA5, 8'h1B, 4'hC, 2'b01, k - 2 * CELLW)));
    end

    // asynchronous reset mid-line
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out", 32'({ven, color}), 32'h0);
    check("mid_rst_vramA", 32'(vramA), 32'h0);
    check("mid_rst_fontA", 32'(fontA), 32'h0);
    @(negedge clock);
    reset = 1'b0; mode = 2'b00; ma = addr;
    for (int k = 1; k <= CELLW; k++) begin
      @(negedge clock);
      if (k == 1)         check("rst_sc0_vramA", 32'(vramA), 32'(addr));
      if (k == CELLW - 1) check("rst_not_yet", 32'({ven, color}), 32'h0);
      if (k == CELLW)     check("rst_resume", 32'({ven, color}), 32'h1C);
    end

    for (int l = 0; l < 8; l++) random_line($urandom_range(4, 12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
